// File: rtl/tap_pkg.sv
// tap_pkg: shared types and constants for the JTAG TAP controller.
//   tap_state_t  - 16 TAP states with the fixed IEEE-style 4-bit encoding
//   instr_sel_t  - data register selected by the decoded instruction
//   *_DEF        - default IDCODE value and opcodes
//   decode_instr - maps the IR parallel output onto a data register select
package tap_pkg;

  typedef enum logic [3:0] {
    TLR   = 4'hF,
    RTI   = 4'hC,
    SelDR = 4'h7,
    CapDR = 4'h6,
    ShDR  = 4'h2,
    Ex1DR = 4'h1,
    PauDR = 4'h3,
    Ex2DR = 4'h0,
    UpdDR = 4'h5,
    SelIR = 4'h4,
    CapIR = 4'hE,
    ShIR  = 4'hA,
    Ex1IR = 4'h9,
    PauIR = 4'hB,
    Ex2IR = 4'h8,
    UpdIR = 4'hD
  } tap_state_t;

  typedef enum logic [1:0] {
    SEL_IDCODE,
    SEL_BYPASS,
    SEL_USER
  } instr_sel_t;

  localparam logic [31:0] IDCODE_VALUE_DEF = 32'h1000_0001;
  localparam logic [7:0]  IDCODE_OP_DEF    = 8'h00;
  localparam logic [7:0]  USER_OP_DEF      = 8'h02;
  localparam logic [7:0]  BYPASS_OP_DEF    = 8'hFF;

  // An explicit BYPASS opcode wins; anything not recognised also falls to BYPASS.
  function automatic instr_sel_t decode_instr(input logic [7:0] ir,
                                              input logic [7:0] idcode_op,
                                              input logic [7:0] user_op,
                                              input logic [7:0] bypass_op);
    if (ir == bypass_op)      return SEL_BYPASS;
    else if (ir == idcode_op) return SEL_IDCODE;
    else if (ir == user_op)   return SEL_USER;
    return SEL_BYPASS;
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// tap_fsm: 16-state TAP state machine clocked by TCLK, steered by TMS.
// Ports:
//   TCLK, TRESETN (async active-low), TMS   - clock, reset, mode select
//   state_o                                  - current state
//   capture/shift/update_ir_o, _dr_o         - Moore strobes from state
//   tlr_o, rti_o                             - Test-Logic-Reset / Run-Test/Idle
module tap_fsm
  import tap_pkg::*;
(
  input  logic       TCLK,
  input  logic       TRESETN,
  input  logic       TMS,
  output tap_state_t state_o,
  output logic       capture_ir_o,
  output logic       shift_ir_o,
  output logic       update_ir_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       tlr_o,
  output logic       rti_o
);

  tap_state_t state_q, state_d;

  always_ff @(posedge TCLK or negedge TRESETN) begin
    if (!TRESETN) state_q <= TLR;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    capture_ir_o = 1'b0;
    shift_ir_o   = 1'b0;
    update_ir_o  = 1'b0;
    capture_dr_o = 1'b0;
    shift_dr_o   = 1'b0;
    update_dr_o  = 1'b0;
    tlr_o        = 1'b0;
    rti_o        = 1'b0;
    case (state_q)
      TLR:   begin state_d = TMS ? TLR   : RTI;   tlr_o = 1'b1; end
      RTI:   begin state_d = TMS ? SelDR : RTI;   rti_o = 1'b1; end
      SelDR: state_d = TMS ? SelIR : CapDR;
      CapDR: begin state_d = TMS ? Ex1DR : ShDR;  capture_dr_o = 1'b1; end
      ShDR:  begin state_d = TMS ? Ex1DR : ShDR;  shift_dr_o   = 1'b1; end
      Ex1DR: state_d = TMS ? UpdDR : PauDR;
      PauDR: state_d = TMS ? Ex2DR : PauDR;
      Ex2DR: state_d = TMS ? UpdDR : ShDR;
      UpdDR: begin state_d = TMS ? SelDR : RTI;   update_dr_o  = 1'b1; end
      SelIR: state_d = TMS ? TLR   : CapIR;
      CapIR: begin state_d = TMS ? Ex1IR : ShIR;  capture_ir_o = 1'b1; end
      ShIR:  begin state_d = TMS ? Ex1IR : ShIR;  shift_ir_o   = 1'b1; end
      Ex1IR: state_d = TMS ? UpdIR : PauIR;
      PauIR: state_d = TMS ? Ex2IR : PauIR;
      Ex2IR: state_d = TMS ? UpdIR : ShIR;
      UpdIR: begin state_d = TMS ? SelDR : RTI;   update_ir_o  = 1'b1; end
      default: state_d = TLR;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/tap_ctrl.sv
// tap_ctrl: JTAG TAP controller top. Wraps tap_fsm, decodes the external
// 8-bit IR, holds the IDCODE and BYPASS data registers and registers TDO.
// Ports:
//   TCLK, TRESETN (async active-low), TMS, TDI  - JTAG pins
//   IRPO[7:0], IRSO                              - external IR parallel/serial out
//   UserSO                                       - external user DR serial out
//   CaptureIR/ShiftIR/UpdateIR                   - IR strobes
//   CaptureDR/ShiftDR/UpdateDR                   - DR strobes (not gated by select)
//   UserSel                                      - USER instruction decoded
//   TestLogicReset, RunTestIdle, State[3:0]      - state visibility
//   TDO, TDOEn                                   - registered serial out + valid
// IDCODE_VALUE bit 0 must be 1 so a chain scan can tell IDCODE from BYPASS.
module tap_ctrl
  import tap_pkg::*;
#(
  parameter logic [31:0] IDCODE_VALUE = IDCODE_VALUE_DEF,
  parameter logic [7:0]  IDCODE_OP    = IDCODE_OP_DEF,
  parameter logic [7:0]  USER_OP      = USER_OP_DEF,
  parameter logic [7:0]  BYPASS_OP    = BYPASS_OP_DEF
)(
  input  logic       TCLK,
  input  logic       TRESETN,
  input  logic       TMS,
  input  logic       TDI,
  input  logic [7:0] IRPO,
  input  logic       IRSO,
  input  logic       UserSO,
  output logic       CaptureIR,
  output logic       ShiftIR,
  output logic       UpdateIR,
  output logic       CaptureDR,
  output logic       ShiftDR,
  output logic       UpdateDR,
  output logic       UserSel,
  output logic       TestLogicReset,
  output logic       RunTestIdle,
  output logic [3:0] State,
  output logic       TDO,
  output logic       TDOEn
);

  tap_state_t state;
  instr_sel_t sel;

  logic [31:0] idcode_q, idcode_d;
  logic        bypass_q, bypass_d;
  logic        tdo_q, tdo_d;
  logic        tdoen_q, tdoen_d;
  logic        dr_so;

  tap_fsm u_fsm (
    .TCLK         (TCLK),
    .TRESETN      (TRESETN),
    .TMS          (TMS),
    .state_o      (state),
    .capture_ir_o (CaptureIR),
    .shift_ir_o   (ShiftIR),
    .update_ir_o  (UpdateIR),
    .capture_dr_o (CaptureDR),
    .shift_dr_o   (ShiftDR),
    .update_dr_o  (UpdateDR),
    .tlr_o        (TestLogicReset),
    .rti_o        (RunTestIdle)
  );

  assign State   = state;
  assign sel     = decode_instr(IRPO, IDCODE_OP, USER_OP, BYPASS_OP);
  assign UserSel = (sel == SEL_USER);

  always_comb begin
    idcode_d = idcode_q;
    bypass_d = bypass_q;
    if (sel == SEL_IDCODE) begin
      if (state == CapDR)     idcode_d = IDCODE_VALUE;
      else if (state == ShDR) idcode_d = {TDI, idcode_q[31:1]};
    end
    // BYPASS is only observable when selected, so it runs unconditionally.
    if (state == CapDR)     bypass_d = 1'b0;
    else if (state == ShDR) bypass_d = TDI;
  end

  always_comb begin
    case (sel)
      SEL_IDCODE: dr_so = idcode_q[0];
      SEL_USER:   dr_so = UserSO;
      default:    dr_so = bypass_q;
    endcase
  end

  // TDO takes the pre-shift serial bit on each shift edge and holds otherwise.
  always_comb begin
    tdo_d   = tdo_q;
    tdoen_d = 1'b0;
    if (state == ShIR) begin
      tdo_d   = IRSO;
      tdoen_d = 1'b1;
    end else if (state == ShDR) begin
      tdo_d   = dr_so;
      tdoen_d = 1'b1;
    end
  end

  always_ff @(posedge TCLK or negedge TRESETN) begin
    if (!TRESETN) begin
      idcode_q <= IDCODE_VALUE;
      bypass_q <= 1'b0;
      tdo_q    <= 1'b0;
      tdoen_q  <= 1'b0;
    end else begin
      idcode_q <= idcode_d;
      bypass_q <= bypass_d;
      tdo_q    <= tdo_d;
      tdoen_q  <= tdoen_d;
    end
  end

  assign TDO   = tdo_q;
  assign TDOEn = tdoen_q;

endmodule

// File: tb/tb_tap_ctrl.sv
module tb_tap_ctrl;

  logic       TCLK = 1'b0;
  logic       TRESETN, TMS, TDI, UserSO;
  logic [7:0] IRPO;
  logic       IRSO;
  logic       CaptureIR, ShiftIR, UpdateIR, CaptureDR, ShiftDR, UpdateDR;
  logic       UserSel, TestLogicReset, RunTestIdle, TDO, TDOEn;
  logic [3:0] State;

  localparam logic [31:0] IDC = 32'h1000_0001;

  int n_chk  = 0;
  int n_pass = 0;
  bit exp_q[$];

  tap_ctrl dut (
    .TCLK(TCLK), .TRESETN(TRESETN), .TMS(TMS), .TDI(TDI),
    .IRPO(IRPO), .IRSO(IRSO), .UserSO(UserSO),
    .CaptureIR(CaptureIR), .ShiftIR(ShiftIR), .UpdateIR(UpdateIR),
    .CaptureDR(CaptureDR), .ShiftDR(ShiftDR), .UpdateDR(UpdateDR),
    .UserSel(UserSel), .TestLogicReset(TestLogicReset), .RunTestIdle(RunTestIdle),
    .State(State), .TDO(TDO), .TDOEn(TDOEn)
  );

  always #5 TCLK = ~TCLK;

  // External 8-bit instruction register driven by the DUT strobes.
  logic [7:0] ir_sh, ir_par;
  always @(posedge TCLK or negedge TRESETN) begin
    if (!TRESETN) begin
      ir_sh  <= 8'h00;
      ir_par <= 8'h00;
    end else begin
      if (TestLogicReset) ir_par <= 8'h00;
      if (CaptureIR)      ir_sh  <= 8'h01;
      else if (ShiftIR)   ir_sh  <= {TDI, ir_sh[7:1]};
      if (UpdateIR)       ir_par <= ir_sh;
    end
  end
  assign IRPO = ir_par;
  assign IRSO = ir_sh[0];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCLK);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 32; i++) exp_q.push_back(w[i]);
  endtask

  task automatic to_tlr();
    repeat (5) step(1'b1, 1'b0);
  endtask

  task automatic load_ir(input logic [7:0] v);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(i == 7, v[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    TRESETN = 1'b0; TMS = 1'b1; TDI = 1'b0; UserSO = 1'b0;
    repeat (2) @(posedge TCLK);
    #1;
    n_chk++; if (State !== 4'hF) $display("FAIL reset_state: got %h want f", State); else n_pass++;
    n_chk++; if (TestLogicReset !== 1'b1) $display("FAIL reset_tlr: got %b want 1", TestLogicReset); else n_pass++;
    n_chk++;
    if ({CaptureIR, ShiftIR, UpdateIR, CaptureDR, ShiftDR, UpdateDR} !== 6'b0)
      $display("FAIL reset_strobes: got %b want 000000",
               {CaptureIR, ShiftIR, UpdateIR, CaptureDR, ShiftDR, UpdateDR});
    else n_pass++;
    n_chk++; if ({TDO, TDOEn} !== 2'b00) $display("FAIL reset_tdo: got %b want 00", {TDO, TDOEn}); else n_pass++;
    TRESETN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      n_chk++;
      if (State !== 4'hF || TestLogicReset !== 1'b1 || TDOEn !== 1'b0)
        $display("FAIL tlr_hold[%0d]: got state %h tlr %b en %b want f 1 0", i, State, TestLogicReset, TDOEn);
      else n_pass++;
    end
  endtask

  task automatic test_ir_path();
    logic       tms_s [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] st_s  [5] = '{4'hC, 4'h7, 4'h4, 4'hE, 4'hA};
    logic       cap_s [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       sh_s  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      step(tms_s[i], 1'b0);
      n_chk++;
      if (State !== st_s[i] || CaptureIR !== cap_s[i] || ShiftIR !== sh_s[i])
        $display("FAIL ir_path[%0d]: got state %h cap %b sh %b want %h %b %b",
                 i, State, CaptureIR, ShiftIR, st_s[i], cap_s[i], sh_s[i]);
      else n_pass++;
    end
    step(1'b1, 1'b0);
    n_chk++;
    if (State !== 4'h9 || TDO !== 1'b1 || TDOEn !== 1'b1)
      $display("FAIL ir_tdo: got state %h tdo %b en %b want 9 1 1", State, TDO, TDOEn);
    else n_pass++;
    step(1'b1, 1'b0);
    n_chk++;
    if (State !== 4'hD || UpdateIR !== 1'b1 || TDOEn !== 1'b0 || TDO !== 1'b1)
      $display("FAIL ir_upd: got state %h upd %b en %b tdo %b want d 1 0 1", State, UpdateIR, TDOEn, TDO);
    else n_pass++;
    step(1'b0, 1'b0);
    n_chk++; if (RunTestIdle !== 1'b1) $display("FAIL ir_rti: got %b want 1", RunTestIdle); else n_pass++;
  endtask

  task automatic test_idcode();
    int en_cnt = 0;
    bit e;
    exp_q.delete();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    n_chk++; if (CaptureDR !== 1'b1) $display("FAIL idc_capture: got %b want 1", CaptureDR); else n_pass++;
    push_word(IDC);
    step(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      step(i == 31, 1'($urandom_range(0, 1)));
      if (TDOEn === 1'b1) begin
        en_cnt++;
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL idc_bit[%0d]: got %b want nothing queued", i, TDO);
        else begin
          e = exp_q.pop_front();
          if (TDO !== e) $display("FAIL idc_bit[%0d]: got %b want %b", i, TDO, e); else n_pass++;
        end
      end
    end
    step(1'b1, 1'b0);
    n_chk++; if (TDOEn !== 1'b0) $display("FAIL idc_en_fall: got %b want 0", TDOEn); else n_pass++;
    step(1'b0, 1'b0);
    n_chk++; if (en_cnt != 32) $display("FAIL idc_en_cnt: got %0d want 32", en_cnt); else n_pass++;
  endtask

  task automatic test_bypass();
    logic tdi_s [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int   en_cnt = 0;
    bit   e;
    load_ir(8'hFF);
    n_chk++; if (UserSel !== 1'b0) $display("FAIL byp_usersel: got %b want 0", UserSel); else n_pass++;
    exp_q.delete();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    exp_q.push_back(1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(tdi_s[i]);
      step(i == 4, tdi_s[i]);
      if (TDOEn === 1'b1) begin
        en_cnt++;
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL byp_bit[%0d]: got %b want nothing queued", i, TDO);
        else begin
          e = exp_q.pop_front();
          if (TDO !== e) $display("FAIL byp_bit[%0d]: got %b want %b", i, TDO, e); else n_pass++;
        end
      end
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    n_chk++; if (en_cnt != 5) $display("FAIL byp_en_cnt: got %0d want 5", en_cnt); else n_pass++;
  endtask

  task automatic test_user();
    logic uso_s [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int   en_cnt = 0;
    bit   e;
    load_ir(8'h02);
    n_chk++; if (UserSel !== 1'b1) $display("FAIL user_sel: got %b want 1", UserSel); else n_pass++;
    exp_q.delete();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n_chk++; if (ShiftDR !== 1'b1) $display("FAIL user_shiftdr: got %b want 1", ShiftDR); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      UserSO = uso_s[i];
      exp_q.push_back(uso_s[i]);
      step(i == 5, 1'b0);
      if (TDOEn === 1'b1) begin
        en_cnt++;
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL user_bit[%0d]: got %b want nothing queued", i, TDO);
        else begin
          e = exp_q.pop_front();
          if (TDO !== e) $display("FAIL user_bit[%0d]: got %b want %b", i, TDO, e); else n_pass++;
        end
      end
    end
    UserSO = 1'b0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    n_chk++; if (en_cnt != 6) $display("FAIL user_en_cnt: got %0d want 6", en_cnt); else n_pass++;
  endtask

  task automatic test_pause();
    int en_cnt = 0;
    bit e;
    to_tlr();
    step(1'b0, 1'b0);
    exp_q.delete();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    push_word(IDC);
    step(1'b0, 1'b0);
    // one bit out, then park in PauDR
    step(1'b1, 1'b1);
    if (TDOEn === 1'b1) begin
      en_cnt++;
      n_chk++;
      e = exp_q.pop_front();
      if (TDO !== e) $display("FAIL pause_bit0: got %b want %b", TDO, e); else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      n_chk++;
      if (State !== 4'h3 || TDOEn !== 1'b0 || TDO !== 1'b1)
        $display("FAIL pause_hold[%0d]: got state %h en %b tdo %b want 3 0 1", i, State, TDOEn, TDO);
      else n_pass++;
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 1; i < 32; i++) begin
      step(i == 31, 1'b0);
      if (TDOEn === 1'b1) begin
        en_cnt++;
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL pause_bit[%0d]: got %b want nothing queued", i, TDO);
        else begin
          e = exp_q.pop_front();
          if (TDO !== e) $display("FAIL pause_bit[%0d]: got %b want %b", i, TDO, e); else n_pass++;
        end
      end
    end
    n_chk++; if (en_cnt != 32) $display("FAIL pause_en_cnt: got %0d want 32", en_cnt); else n_pass++;
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    n_chk++; if (State !== 4'h4) $display("FAIL pause_tlr4: got %h want 4", State); else n_pass++;
    step(1'b1, 1'b0);
    n_chk++; if (State !== 4'hF) $display("FAIL pause_tlr5: got %h want f", State); else n_pass++;
  endtask

  task automatic test_all_states();
    int         plen [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
    logic [7:0] pbit [16] = '{8'b0, 8'b0, 8'b10, 8'b010, 8'b0010, 8'b1010, 8'b01010,
                              8'b101010, 8'b11010, 8'b110, 8'b0110, 8'b00110,
                              8'b10110, 8'b010110, 8'b1010110, 8'b110110};
    logic [3:0] pst  [16] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                              4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
    logic [7:0] b;
    to_tlr();
    for (int s = 0; s < 16; s++) begin
      b = pbit[s];
      for (int k = 0; k < plen[s]; k++) step(b[k], 1'b0);
      n_chk++;
      if (State !== pst[s]) $display("FAIL walk_state[%0d]: got %h want %h", s, State, pst[s]); else n_pass++;
      to_tlr();
      n_chk++;
      if (State !== 4'hF) $display("FAIL walk_tlr[%0d]: got %h want f", s, State); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int en_cnt = 0;
    bit e;
    step(1'b0, 1'b0);
    exp_q.delete();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    push_word(IDC);
    step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      if (TDOEn === 1'b1) begin
        n_chk++;
        e = exp_q.pop_front();
        if (TDO !== e) $display("FAIL mid_bit[%0d]: got %b want %b", i, TDO, e); else n_pass++;
      end
    end
    #2 TRESETN = 1'b0;
    #1;
    n_chk++;
    if (State !== 4'hF || TestLogicReset !== 1'b1 || TDOEn !== 1'b0 || TDO !== 1'b0 || ShiftDR !== 1'b0)
      $display("FAIL mid_reset: got state %h tlr %b en %b tdo %b sh %b want f 1 0 0 0",
               State, TestLogicReset, TDOEn, TDO, ShiftDR);
    else n_pass++;
    exp_q.delete();
    @(posedge TCLK);
    #1 TRESETN = 1'b1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    push_word(IDC);
    step(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      step(i == 31, 1'b1);
      if (TDOEn === 1'b1) begin
        en_cnt++;
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL reread_bit[%0d]: got %b want nothing queued", i, TDO);
        else begin
          e = exp_q.pop_front();
          if (TDO !== e) $display("FAIL reread_bit[%0d]: got %b want %b", i, TDO, e); else n_pass++;
        end
      end
    end
    n_chk++; if (en_cnt != 32) $display("FAIL reread_en_cnt: got %0d want 32", en_cnt); else n_pass++;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ir_path();
    test_idcode();
    test_bypass();
    test_user();
    test_pause();
    test_all_states();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
